// File: rtl/rv32_pkg.sv
// Shared RV32 constants and the instruction-memory responder state encoding.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous read port with enable, one write port, write-first bypass.
module imem_array #(
  parameter int unsigned Depth     = 1024,
  parameter int unsigned Width     = 32,
  parameter logic [31:0] ResetData = 32'h0000_0013
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     re_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Only the read register is reset so the response word starts out as ResetData.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= Width'(ResetData);
    end else if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding fetch, programmable wait states, flush on redirect.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] NOP_INST    = rv32_pkg::NOP_INST
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [rv32_pkg::XLEN-1:0] req_addr,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [rv32_pkg::XLEN-1:0] rsp_inst,
  output logic [rv32_pkg::XLEN-1:0] rsp_addr,
  output logic                      rsp_err,
  input  logic                      flush,
  input  logic                      ld_we,
  input  logic [rv32_pkg::XLEN-1:0] ld_addr,
  input  logic [rv32_pkg::XLEN-1:0] ld_data
);
  import rv32_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  imem_state_e     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, rsp_addr_q;
  logic            err_q;
  logic            accept, sample, sample_err, ld_ok;
  logic [XLEN-1:0] sample_addr, arr_rdata;
  logic            unused_ld_addr;

  assign unused_ld_addr = ^ld_addr[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sample  = 1'b0;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StResp: begin
          if ((state_q == StResp) && rsp_ready) begin
            state_d = StIdle;
          end
          if (accept) begin
            // With no wait states the array is read on the accept edge itself.
            if (WAIT_CYCLES == 0) begin
              sample  = 1'b1;
              state_d = StResp;
            end else begin
              cnt_d   = 4'(WAIT_CYCLES);
              state_d = StWait;
            end
          end
        end
        StWait: begin
          if (cnt_q <= 4'd1) begin
            sample  = 1'b1;
            cnt_d   = 4'd0;
            state_d = StResp;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    req_ready = rst & ~flush & ((state_q == StIdle) | ((state_q == StResp) & rsp_ready));
    rsp_valid = (state_q == StResp);
  end

  assign accept      = req_valid & req_ready;
  assign sample_addr = (WAIT_CYCLES == 0) ? req_addr : addr_q;
  assign sample_err  = (sample_addr[1:0] != 2'b00) |
                       ({2'b00, sample_addr[XLEN-1:2]} >= DEPTH_WORDS);
  assign ld_ok       = ld_we & ({2'b00, ld_addr[XLEN-1:2]} < DEPTH_WORDS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      rsp_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        addr_q <= req_addr;
      end
      if (sample) begin
        rsp_addr_q <= sample_addr;
        err_q      <= sample_err;
      end
    end
  end

  imem_array #(
    .Depth     (DEPTH_WORDS),
    .Width     (XLEN),
    .ResetData (NOP_INST)
  ) u_array (
    .clk_i   (clk),
    .rst_ni  (rst),
    .re_i    (sample & ~sample_err),
    .raddr_i (sample_addr[AW+1:2]),
    .rdata_o (arr_rdata),
    .we_i    (ld_ok),
    .waddr_i (ld_addr[AW+1:2]),
    .wdata_i (ld_data)
  );

  assign rsp_inst = err_q ? NOP_INST : arr_rdata;
  assign rsp_addr = rsp_addr_q;
  assign rsp_err  = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: one instance with a wait state, one with none, sharing clock/loader.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, flush, ld_we;
  logic [31:0] ld_addr, ld_data;

  logic        req_valid_a, req_ready_a, rsp_valid_a, rsp_ready_a, rsp_err_a;
  logic [31:0] req_addr_a, rsp_inst_a, rsp_addr_a;
  logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b, rsp_err_b;
  logic [31:0] req_addr_b, rsp_inst_b, rsp_addr_b;

  int   n_cmp = 0;
  int   n_err = 0;
  int   got_a = 0;
  int   got_b = 0;
  rsp_t q_a[$];
  rsp_t q_b[$];
  rsp_t ea, eb;
  vec_t vecs[8];

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(1), .NOP_INST(NOP)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_addr(req_addr_a), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_inst(rsp_inst_a), .rsp_addr(rsp_addr_a), .rsp_err(rsp_err_a), .flush(flush),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  imem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .NOP_INST(NOP)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_addr(req_addr_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_inst(rsp_inst_b), .rsp_addr(rsp_addr_b), .rsp_err(rsp_err_b), .flush(1'b0),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboards: every completed handshake pops the oldest expected response.
  always @(negedge clk) begin
    if (rst && rsp_valid_a && rsp_ready_a) begin
      got_a++;
      if (q_a.size() == 0) begin
        check("a_unexpected_rsp", rsp_addr_a, 32'hFFFF_FFFF);
      end else begin
        ea = q_a.pop_front();
        check("a_rsp_addr", rsp_addr_a, ea.addr);
        check("a_rsp_inst", rsp_inst_a, ea.inst);
        check("a_rsp_err", {31'd0, rsp_err_a}, {31'd0, ea.err});
      end
    end
    if (rst && rsp_valid_b && rsp_ready_b) begin
      got_b++;
      if (q_b.size() == 0) begin
        check("b_unexpected_rsp", rsp_addr_b, 32'hFFFF_FFFF);
      end else begin
        eb = q_b.pop_front();
        check("b_rsp_addr", rsp_addr_b, eb.addr);
        check("b_rsp_inst", rsp_inst_b, eb.inst);
        check("b_rsp_err", {31'd0, rsp_err_b}, {31'd0, eb.err});
      end
    end
  end

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  // Drives a request on instance A until accepted; returns 1ns after the accept edge.
  task automatic issue_a(input logic [31:0] a, input logic [31:0] inst, input logic err);
    bit ok = 1'b0;
    @(posedge clk); #1;
    req_valid_a = 1'b1; req_addr_a = a;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready_a) ok = 1'b1;
    end
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    check("a_accept", {31'd0, ok}, 32'd1);
    if (ok) q_a.push_back('{addr: a, inst: inst, err: err});
  endtask

  task automatic wait_rsp_a(input int n);
    for (int i = 0; i < 20 && got_a < n; i++) @(negedge clk);
    check("a_rsp_count", got_a, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{addr: 32'h0000_0004, inst: 32'hC0DE_0001, err: 1'b0};
    vecs[1] = '{addr: 32'h0000_0008, inst: 32'hC0DE_0002, err: 1'b0};
    vecs[2] = '{addr: 32'h0000_003C, inst: 32'hC0DE_000F, err: 1'b0};
    vecs[3] = '{addr: 32'h0000_0002, inst: NOP,           err: 1'b1};
    vecs[4] = '{addr: 32'h0000_0040, inst: NOP,           err: 1'b1};
    vecs[5] = '{addr: 32'hFFFF_FFFC, inst: NOP,           err: 1'b1};
    vecs[6] = '{addr: 32'h0000_0001, inst: NOP,           err: 1'b1};
    vecs[7] = '{addr: 32'h0000_000C, inst: 32'hC0DE_0003, err: 1'b0};

    rst = 1'b0; flush = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    req_valid_a = 1'b0; req_addr_a = '0; rsp_ready_a = 1'b0;
    req_valid_b = 1'b0; req_addr_b = '0; rsp_ready_b = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
    check("rst_rsp_inst", rsp_inst_a, NOP);
    check("rst_rsp_addr", rsp_addr_a, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err_a}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready_a}, 32'd0);
    rst = 1'b1;

    load(32'd0, 32'h0050_0093);
    for (int i = 1; i < 16; i++) load(32'(i * 4), 32'hC0DE_0000 + 32'(i));
    load(32'h0000_0040, 32'hDEAD_BEEF);  // out of range, must not alias onto word 0

    // Latency and backpressure on a single fetch of word 0.
    issue_a(32'd0, 32'h0050_0093, 1'b0);
    @(negedge clk);
    check("lat_wait_valid", {31'd0, rsp_valid_a}, 32'd0);
    @(negedge clk);
    check("lat_resp_valid", {31'd0, rsp_valid_a}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, rsp_valid_a}, 32'd1);
      check("bp_inst", rsp_inst_a, 32'h0050_0093);
      check("bp_req_ready", {31'd0, req_ready_a}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_idle", {31'd0, rsp_valid_a}, 32'd0);
    check("bp_release_ready", {31'd0, req_ready_a}, 32'd1);
    check("bp_rsp_count", got_a, 1);

    foreach (vecs[i]) begin
      issue_a(vecs[i].addr, vecs[i].inst, vecs[i].err);
      wait_rsp_a(got_a + 1);
    end

    // Back-to-back on the zero-wait instance: one response per cycle.
    rsp_ready_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      req_valid_b = 1'b1; req_addr_b = 32'(i * 4);
      q_b.push_back('{addr: 32'(i * 4),
                      inst: (i == 0) ? 32'h0050_0093 : 32'hC0DE_0000 + 32'(i), err: 1'b0});
      @(negedge clk);
      check("b2b_req_ready", {31'd0, req_ready_b}, 32'd1);
      if (i > 0) check("b2b_rsp_valid", {31'd0, rsp_valid_b}, 32'd1);
    end
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    @(negedge clk);
    check("b2b_last_valid", {31'd0, rsp_valid_b}, 32'd1);
    @(negedge clk);
    check("b2b_count", got_b, 4);
    check("b2b_idle", {31'd0, rsp_valid_b}, 32'd0);

    // Flush while waiting: the word never appears, outputs hold their last values.
    @(posedge clk); #1;
    req_valid_a = 1'b1; req_addr_a = 32'd8;
    @(negedge clk);
    check("fl_pre_ready", {31'd0, req_ready_a}, 32'd1);
    @(posedge clk); #1;
    req_valid_a = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("fl_req_ready", {31'd0, req_ready_a}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fl_no_valid", {31'd0, rsp_valid_a}, 32'd0);
    end
    check("fl_hold_addr", rsp_addr_a, 32'h0000_000C);
    check("fl_hold_inst", rsp_inst_a, 32'hC0DE_0003);

    // Flush coincident with a request: not accepted.
    @(posedge clk); #1;
    req_valid_a = 1'b1; req_addr_a = 32'd4; flush = 1'b1;
    @(negedge clk);
    check("fl_coinc_ready", {31'd0, req_ready_a}, 32'd0);
    @(posedge clk); #1;
    req_valid_a = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fl_coinc_no_valid", {31'd0, rsp_valid_a}, 32'd0);
    end
    issue_a(32'd4, 32'hC0DE_0001, 1'b0);
    wait_rsp_a(got_a + 1);

    // Loader write to word 3 on the sample edge of a fetch of address 12.
    rsp_ready_a = 1'b0;
    issue_a(32'd12, 32'h1234_5678, 1'b0);
    ld_we = 1'b1; ld_addr = 32'd12; ld_data = 32'h1234_5678;
    @(posedge clk); #1;
    ld_we = 1'b0;
    @(negedge clk);
    check("col_valid", {31'd0, rsp_valid_a}, 32'd1);
    check("col_inst", rsp_inst_a, 32'h1234_5678);
    check("col_addr", rsp_addr_a, 32'd12);

    // Asynchronous reset while holding a response.
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, rsp_valid_a}, 32'd0);
    check("mid_rst_inst", rsp_inst_a, NOP);
    check("mid_rst_addr", rsp_addr_a, 32'd0);
    check("mid_rst_err", {31'd0, rsp_err_a}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready_a}, 32'd0);
    if (q_a.size() > 0) void'(q_a.pop_front());
    @(negedge clk);
    rst = 1'b1;

    // Array contents survive reset and hold the collision write.
    rsp_ready_a = 1'b1;
    issue_a(32'd12, 32'h1234_5678, 1'b0);
    wait_rsp_a(got_a + 1);

    check("sb_a_drained", q_a.size(), 0);
    check("sb_b_drained", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder serving the fetch stage's PC requests.
- Accepts one word-aligned fetch address per valid/ready handshake and returns the instruction word after a configurable number of wait states.
- Returns the instruction on a valid/ready response channel, tagged with its address and an error flag.
- Provides a loader write port for program download, and a flush input that discards in-flight fetches on a branch/jump redirect.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit instruction words in the array; power of two.
- WAIT_CYCLES, 1, wait states between request accept and array sample; 0..15.
- NOP_INST, 32'h00000013, word returned on error and at reset (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- req_valid  input  1  fetch request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_addr  input  32  byte address of the instruction (PC).
- rsp_valid  output  1  response word available.
- rsp_ready  input  1  fetch stage consumes the response this cycle.
- rsp_inst  output  32  instruction word.
- rsp_addr  output  32  address the response belongs to.
- rsp_err  output  1  misaligned or out-of-range request.
- flush  input  1  redirect; drop the outstanding request or response.
- ld_we  input  1  loader write enable.
- ld_addr  input  32  loader byte address; bits [1:0] ignored.
- ld_data  input  32  loader write data.

Behaviour:
- Reset (rst=0, async): state=IDLE, rsp_valid=0, rsp_inst=NOP_INST, rsp_addr=0, rsp_err=0, wait counter=0. req_ready=0 while rst=0. Array contents are not reset.
- One outstanding request maximum. FSM states: IDLE, WAIT, RESP.
- req_ready = rst & ~flush & (state==IDLE | (state==RESP & rsp_ready)).
- Accept = req_valid & req_ready. On accept, latch req_addr and load counter=WAIT_CYCLES.
  - If WAIT_CYCLES==0, go directly to the sample step.
  - Otherwise go to WAIT.
- WAIT: decrement the counter each cycle. When the counter reaches 0, do the sample step.
- Sample step: register rsp_addr=latched addr and compute the error condition.
  - err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH_WORDS).
  - err=1: rsp_inst=NOP_INST, rsp_err=1.
  - err=0: rsp_inst=array[addr[log2(DEPTH_WORDS)+1:2]], rsp_err=0.
  - Then go to RESP.
- Latency: accept at edge T gives rsp_valid=1 from cycle T+1+WAIT_CYCLES.
- RESP: rsp_valid=1. rsp_inst, rsp_addr and rsp_err stay stable until rsp_valid & rsp_ready.
  - Handshake with no new accept: go to IDLE.
  - Handshake together with a new accept (back-to-back): go to WAIT, or to the sample step if WAIT_CYCLES==0.
  - Back-to-back gives full throughput of 1 word per cycle when WAIT_CYCLES==0.
- Flush has priority over everything except reset.
  - In WAIT or RESP: go to IDLE next cycle; rsp_valid=0 from that cycle; the pending word is discarded.
  - A req_valid coincident with flush is not accepted (req_ready=0).
  - rsp_inst and rsp_addr keep their last values; only rsp_valid drops.
- Loader: ld_we=1 writes ld_data to array[ld_addr word index] at the clock edge.
  - Out-of-range loader writes are ignored.
  - Sample collision (same word, same edge): the response carries ld_data (write-first bypass).
- Address arithmetic uses the full 32 bits; no wrap-around. Any out-of-range address reports err.
- Asserting reset mid-operation aborts the transaction immediately; outputs return to reset values asynchronously.

Decomposition:
- Shared package rv32_pkg holds:
  - the NOP_INST constant;
  - the imem FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - the XLEN=32 constant.
- One sub-module: imem_array.
  - Contents: DEPTH_WORDS x 32 storage, one synchronous read with read-enable, one synchronous write port, write-first bypass.
- FSM, counter, error check and output registers live in imem_responder.

Test Plan:
- Reset then single fetch, WAIT_CYCLES=1: load array[0]=32'h00500093, request addr 0 at cycle 2 -> rsp_valid at cycle 4, rsp_inst=32'h00500093, rsp_addr=0, rsp_err=0.
- Backpressure: hold rsp_ready=0 for 3 cycles in RESP -> rsp_valid stays 1, rsp_inst stable, req_ready=0. Release -> handshake, back to IDLE.
- Back-to-back, WAIT_CYCLES=0: addrs 0,4,8,12 with rsp_ready=1 -> one response per cycle, in order, rsp_addr matches each request.
- Errors: req_addr=32'h00000002 -> rsp_err=1, rsp_inst=32'h00000013. req_addr=4*DEPTH_WORDS -> rsp_err=1.
- Flush: flush in WAIT -> no rsp_valid for that request. flush with req_valid=1 in the same cycle -> req_ready=0, no accept. Next request afterwards is served normally.
- Loader collision plus reset: ld_we to word 3 on the same edge as the addr-12 sample -> rsp_inst=ld_data. Assert rst=0 in RESP -> rsp_valid=0 immediately, rsp_inst=NOP_INST.
